// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//
// Hazard and exception sequencer for a four-register pipeline
// (IF_ID, ID_EX, EX_MEM, MEM_WB). It decides every cycle which pipeline
// registers load, which ones clear, and where the PC comes from.
//
// Ports
//   clk, reset            falling-edge clock, asynchronous active-low reset
//   id_src/id_src_valid   four 3-bit decoded source registers and their valids
//   branch_taken          taken branch resolved in ID
//   p1_memRead/p1_rd_load load in EX and its destination register
//   p1_cause/p1_invalid   arithmetic / invalid-opcode exception in EX
//   mem_req/mem_ready     MEM-stage access pending / completing this cycle
//   pc_write, pc_sel      PC enable; 0 sequential, 1 branch target, 2 vector
//   *_Write, *regWrite    pipeline register enables
//   if/id/ex/wb_flush     synchronous clears of the pipeline registers
//   epc_write/cause_write capture EX-stage PC and exc_cause
//   exc_cause             00 arithmetic, 01 invalid opcode, 10 bus timeout
//   ctrl_state            00 RUN, 01 MEM_WAIT, 10 EXC
//
// Outputs are Mealy (state plus current inputs). All state advances on the
// falling edge, in step with the pipeline registers it controls.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT     = 15,
    parameter int EXC_MASK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] id_src,
    input  logic [3:0]  id_src_valid,
    input  logic        branch_taken,
    input  logic        p1_memRead,
    input  logic [2:0]  p1_rd_load,
    input  logic        p1_cause,
    input  logic        p1_invalid,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        IF_Write,
    output logic        ID_Write,
    output logic        EX_MEMregWrite,
    output logic        MEM_WBregWrite,
    output logic        if_flush,
    output logic        id_flush,
    output logic        ex_flush,
    output logic        wb_flush,
    output logic        epc_write,
    output logic        cause_write,
    output logic [1:0]  exc_cause,
    output logic [1:0]  ctrl_state
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        EXC      = 2'b10
    } state_t;

    localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);
    localparam logic [2:0] MASK_VAL    = 3'(EXC_MASK_CYCLES);

    state_t     state, stateNxt;
    logic [7:0] waitCnt, waitCntNxt;
    logic [2:0] maskCnt, maskCntNxt;

    logic loadUse;
    logic memStall;
    logic excReq;

    // A load in EX whose destination is read by any valid decoded source.
    always_comb begin
        loadUse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (id_src_valid[i] && (id_src[3*i +: 3] == p1_rd_load))
                loadUse = 1'b1;
        end
        loadUse = loadUse & p1_memRead;
    end

    assign memStall = mem_req & ~mem_ready;
    assign excReq   = p1_cause | p1_invalid;

    always_comb begin
        pc_write       = 1'b1;
        pc_sel         = 2'd0;
        IF_Write       = 1'b1;
        ID_Write       = 1'b1;
        EX_MEMregWrite = 1'b1;
        MEM_WBregWrite = 1'b1;
        if_flush       = 1'b0;
        id_flush       = 1'b0;
        ex_flush       = 1'b0;
        wb_flush       = 1'b0;
        epc_write      = 1'b0;
        cause_write    = 1'b0;
        exc_cause      = 2'b00;
        stateNxt       = state;
        waitCntNxt     = waitCnt;
        maskCntNxt     = maskCnt;

        if (state == MEM_WAIT) begin
            if (mem_ready) begin
                // Completion beats a coincident timeout.
                stateNxt   = RUN;
                waitCntNxt = 8'd0;
            end else if (waitCnt == TIMEOUT_VAL) begin
                pc_sel      = 2'd2;
                if_flush    = 1'b1;
                id_flush    = 1'b1;
                ex_flush    = 1'b1;
                wb_flush    = 1'b1;
                epc_write   = 1'b1;
                cause_write = 1'b1;
                exc_cause   = 2'b10;
                stateNxt    = EXC;
                waitCntNxt  = 8'd0;
                maskCntNxt  = MASK_VAL;
            end else begin
                pc_write       = 1'b0;
                IF_Write       = 1'b0;
                ID_Write       = 1'b0;
                EX_MEMregWrite = 1'b0;
                wb_flush       = 1'b1;
                if (waitCnt != 8'hFF)
                    waitCntNxt = waitCnt + 8'd1;
            end
        end else begin
            // RUN and EXC share the hazard path; EXC only masks exceptions
            // and counts down its window.
            if (state == EXC) begin
                if (maskCnt > 3'd1) begin
                    maskCntNxt = maskCnt - 3'd1;
                end else begin
                    maskCntNxt = 3'd0;
                    stateNxt   = RUN;
                end
            end

            if (memStall) begin
                pc_write       = 1'b0;
                IF_Write       = 1'b0;
                ID_Write       = 1'b0;
                EX_MEMregWrite = 1'b0;
                wb_flush       = 1'b1;
                stateNxt       = MEM_WAIT;
                waitCntNxt     = 8'd1;
                maskCntNxt     = 3'd0;
            end else if ((state == RUN) && excReq) begin
                pc_sel      = 2'd2;
                if_flush    = 1'b1;
                id_flush    = 1'b1;
                ex_flush    = 1'b1;
                epc_write   = 1'b1;
                cause_write = 1'b1;
                exc_cause   = p1_invalid ? 2'b01 : 2'b00;
                stateNxt    = EXC;
                maskCntNxt  = MASK_VAL;
            end else if (loadUse) begin
                // ID is held, so a taken branch here is simply re-seen next cycle.
                pc_write = 1'b0;
                IF_Write = 1'b0;
                id_flush = 1'b1;
            end else if (branch_taken) begin
                pc_sel   = 2'd1;
                if_flush = 1'b1;
            end
        end

        ctrl_state = state;

        // Reset forces every output low immediately, not just at the next edge.
        if (!reset) begin
            pc_write       = 1'b0;
            pc_sel         = 2'd0;
            IF_Write       = 1'b0;
            ID_Write       = 1'b0;
            EX_MEMregWrite = 1'b0;
            MEM_WBregWrite = 1'b0;
            if_flush       = 1'b0;
            id_flush       = 1'b0;
            ex_flush       = 1'b0;
            wb_flush       = 1'b0;
            epc_write      = 1'b0;
            cause_write    = 1'b0;
            exc_cause      = 2'b00;
            ctrl_state     = 2'b00;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            waitCnt <= 8'd0;
            maskCnt <= 3'd0;
        end else begin
            state   <= stateNxt;
            waitCnt <= waitCntNxt;
            maskCnt <= maskCntNxt;
        end
    end

endmodule
